// File: rtl/plab4_net_terminal_ifc_tp_pkg.sv
// rtl/plab4_net_terminal_ifc_tp_pkg.sv - net message layout helpers for the terminal interface
// Layout, MSB first: {dest, src, opaque, payload}.
package plab4_net_terminal_ifc_tp_pkg;

  function automatic int unsigned net_msg_nbits(input int unsigned p, input int unsigned o,
                                                input int unsigned s);
    return p + o + 2 * s;
  endfunction

  function automatic int unsigned net_msg_src_lsb(input int unsigned p, input int unsigned o);
    return p + o;
  endfunction

  function automatic int unsigned net_msg_dest_lsb(input int unsigned p, input int unsigned o,
                                                   input int unsigned s);
    return p + o + s;
  endfunction

endpackage

// File: rtl/plab4_net_TerminalEjectQueue_TP.sv
// rtl/plab4_net_TerminalEjectQueue_TP.sv - count-based ejection FIFO with registered full/empty
// Power-of-two depth lets the pointers wrap by plain truncation.
module plab4_net_TerminalEjectQueue_TP #(
  parameter int unsigned p_msg_nbits = 41,
  parameter int unsigned p_num_msgs  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val_i,
  output logic                   enq_rdy_o,
  input  logic [p_msg_nbits-1:0] enq_msg_i,
  output logic                   deq_val_o,
  input  logic                   deq_rdy_i,
  output logic [p_msg_nbits-1:0] deq_msg_o
);

  localparam int unsigned c_addr_nbits = $clog2(p_num_msgs);
  localparam int unsigned c_cnt_nbits  = $clog2(p_num_msgs + 1);
  localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_num_msgs);

  logic [p_msg_nbits-1:0]  mem_q [p_num_msgs];
  logic [c_addr_nbits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_nbits-1:0]  cnt_q, cnt_d;
  logic                    full_q, full_d, empty_q, empty_d;
  logic                    enq_fire, deq_fire;

  assign enq_rdy_o = !full_q;
  assign deq_val_o = !empty_q;
  assign deq_msg_o = mem_q[rd_ptr_q];
  assign enq_fire  = enq_val_i && !full_q;
  assign deq_fire  = deq_rdy_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    if (enq_fire && !deq_fire)      cnt_d = cnt_q + 1'b1;
    else if (!enq_fire && deq_fire) cnt_d = cnt_q - 1'b1;
    full_d  = (cnt_d == c_depth);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: empty_q masks stale entries.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_msg_i;
  end

endmodule

// File: rtl/plab4_net_terminal_ifc_tp.sv
// rtl/plab4_net_terminal_ifc_tp.sv - timing-protected terminal interface between two domains and a router
// Every per-domain path is built from that domain's signals only; `domain` steers ejection.
module plab4_net_terminal_ifc_tp
  import plab4_net_terminal_ifc_tp_pkg::*;
#(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_num_routers   = 8,
  parameter int unsigned p_num_msgs      = 2,
  localparam int unsigned c_net_msg_nbits =
    net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       domain,
  input  logic                       send_val_d0,
  output logic                       send_rdy_d0,
  input  logic [p_srcdest_nbits-1:0] send_dest_d0,
  input  logic [p_opaque_nbits-1:0]  send_opaque_d0,
  input  logic [p_payload_nbits-1:0] send_payload_d0,
  input  logic                       send_val_d1,
  output logic                       send_rdy_d1,
  input  logic [p_srcdest_nbits-1:0] send_dest_d1,
  input  logic [p_opaque_nbits-1:0]  send_opaque_d1,
  input  logic [p_payload_nbits-1:0] send_payload_d1,
  output logic                       net_in_val_d0,
  input  logic                       net_in_rdy_d0,
  output logic [c_net_msg_nbits-1:0] net_in_msg_d0,
  output logic                       net_in_val_d1,
  input  logic                       net_in_rdy_d1,
  output logic [c_net_msg_nbits-1:0] net_in_msg_d1,
  input  logic                       net_out_val,
  output logic                       net_out_rdy,
  input  logic [c_net_msg_nbits-1:0] net_out_msg,
  output logic                       recv_val_d0,
  input  logic                       recv_rdy_d0,
  output logic [c_net_msg_nbits-1:0] recv_msg_d0,
  output logic                       recv_val_d1,
  input  logic                       recv_rdy_d1,
  output logic [c_net_msg_nbits-1:0] recv_msg_d1,
  output logic                       misroute_d0,
  output logic                       misroute_d1
);

  localparam int unsigned c_dest_lsb =
    net_msg_dest_lsb(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);
  localparam logic [p_srcdest_nbits-1:0] c_router_id = p_srcdest_nbits'(p_router_id);

  logic [1:0]                 send_val, send_rdy, net_in_val, net_in_rdy;
  logic [p_srcdest_nbits-1:0] send_dest    [2];
  logic [p_opaque_nbits-1:0]  send_opaque  [2];
  logic [p_payload_nbits-1:0] send_payload [2];
  logic [c_net_msg_nbits-1:0] net_in_msg   [2];
  logic [1:0]                 eq_enq_val, eq_enq_rdy, eq_deq_val, eq_deq_rdy, misroute;
  logic [c_net_msg_nbits-1:0] eq_deq_msg   [2];
  logic [p_srcdest_nbits-1:0] out_dest;
  logic                       out_dest_bad;

  assign send_val        = {send_val_d1, send_val_d0};
  assign send_dest[0]    = send_dest_d0;
  assign send_dest[1]    = send_dest_d1;
  assign send_opaque[0]  = send_opaque_d0;
  assign send_opaque[1]  = send_opaque_d1;
  assign send_payload[0] = send_payload_d0;
  assign send_payload[1] = send_payload_d1;
  assign net_in_rdy      = {net_in_rdy_d1, net_in_rdy_d0};
  assign eq_deq_rdy      = {recv_rdy_d1, recv_rdy_d0};

  assign send_rdy_d0   = send_rdy[0];
  assign send_rdy_d1   = send_rdy[1];
  assign net_in_val_d0 = net_in_val[0];
  assign net_in_val_d1 = net_in_val[1];
  assign net_in_msg_d0 = net_in_msg[0];
  assign net_in_msg_d1 = net_in_msg[1];
  assign recv_val_d0   = reset && eq_deq_val[0];
  assign recv_val_d1   = reset && eq_deq_val[1];
  assign recv_msg_d0   = eq_deq_msg[0];
  assign recv_msg_d1   = eq_deq_msg[1];
  assign misroute_d0   = misroute[0];
  assign misroute_d1   = misroute[1];

  // Ready only looks at the selected domain's registered full flag.
  assign net_out_rdy  = reset && (domain ? eq_enq_rdy[1] : eq_enq_rdy[0]);
  assign out_dest     = net_out_msg[c_dest_lsb +: p_srcdest_nbits];
  assign out_dest_bad = (out_dest != c_router_id) || (32'(out_dest) >= 32'(p_num_routers));

  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic                       inj_full_q, inj_full_d;
    logic [c_net_msg_nbits-1:0] inj_msg_q, inj_msg_d;
    logic                       send_fire;
    logic                       misroute_q, misroute_d;

    assign send_rdy[d]   = reset && (!inj_full_q || net_in_rdy[d]);
    assign send_fire     = send_val[d] && send_rdy[d];
    assign net_in_val[d] = reset && inj_full_q;
    assign net_in_msg[d] = inj_msg_q;

    always_comb begin
      inj_full_d = inj_full_q;
      inj_msg_d  = inj_msg_q;
      if (send_fire) begin
        inj_full_d = 1'b1;
        inj_msg_d  = {send_dest[d], c_router_id, send_opaque[d], send_payload[d]};
      end else if (inj_full_q && net_in_rdy[d]) begin
        inj_full_d = 1'b0;
      end
    end

    assign eq_enq_val[d] = net_out_val && net_out_rdy && (domain == 1'(d));
    assign misroute_d    = misroute_q || (eq_enq_val[d] && out_dest_bad);
    assign misroute[d]   = misroute_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        inj_full_q <= 1'b0;
        inj_msg_q  <= '0;
        misroute_q <= 1'b0;
      end else begin
        inj_full_q <= inj_full_d;
        inj_msg_q  <= inj_msg_d;
        misroute_q <= misroute_d;
      end
    end

    plab4_net_TerminalEjectQueue_TP #(
      .p_msg_nbits (c_net_msg_nbits),
      .p_num_msgs  (p_num_msgs)
    ) u_eject_q (
      .clk       (clk),
      .reset     (reset),
      .enq_val_i (eq_enq_val[d]),
      .enq_rdy_o (eq_enq_rdy[d]),
      .enq_msg_i (net_out_msg),
      .deq_val_o (eq_deq_val[d]),
      .deq_rdy_i (eq_deq_rdy[d]),
      .deq_msg_o (eq_deq_msg[d])
    );
  end

endmodule

// File: tb/tb_plab4_net_terminal_ifc_tp.sv
// tb/tb_plab4_net_terminal_ifc_tp.sv - scoreboard bench for the terminal interface
module tb_plab4_net_terminal_ifc_tp;

  localparam int W = 41;

  logic clk = 1'b0;
  logic reset, domain;
  logic send_val_d0, send_rdy_d0, send_val_d1, send_rdy_d1;
  logic [2:0] send_dest_d0, send_dest_d1, send_opaque_d0, send_opaque_d1;
  logic [31:0] send_payload_d0, send_payload_d1;
  logic net_in_val_d0, net_in_rdy_d0, net_in_val_d1, net_in_rdy_d1;
  logic [W-1:0] net_in_msg_d0, net_in_msg_d1, net_out_msg, recv_msg_d0, recv_msg_d1;
  logic net_out_val, net_out_rdy;
  logic recv_val_d0, recv_rdy_d0, recv_val_d1, recv_rdy_d1;
  logic misroute_d0, misroute_d1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb [4][$];

  always #5 clk = ~clk;

  plab4_net_terminal_ifc_tp #(.p_router_id(2)) dut (
    .clk(clk), .reset(reset), .domain(domain),
    .send_val_d0(send_val_d0), .send_rdy_d0(send_rdy_d0), .send_dest_d0(send_dest_d0),
    .send_opaque_d0(send_opaque_d0), .send_payload_d0(send_payload_d0),
    .send_val_d1(send_val_d1), .send_rdy_d1(send_rdy_d1), .send_dest_d1(send_dest_d1),
    .send_opaque_d1(send_opaque_d1), .send_payload_d1(send_payload_d1),
    .net_in_val_d0(net_in_val_d0), .net_in_rdy_d0(net_in_rdy_d0), .net_in_msg_d0(net_in_msg_d0),
    .net_in_val_d1(net_in_val_d1), .net_in_rdy_d1(net_in_rdy_d1), .net_in_msg_d1(net_in_msg_d1),
    .net_out_val(net_out_val), .net_out_rdy(net_out_rdy), .net_out_msg(net_out_msg),
    .recv_val_d0(recv_val_d0), .recv_rdy_d0(recv_rdy_d0), .recv_msg_d0(recv_msg_d0),
    .recv_val_d1(recv_val_d1), .recv_rdy_d1(recv_rdy_d1), .recv_msg_d1(recv_msg_d1),
    .misroute_d0(misroute_d0), .misroute_d1(misroute_d1)
  );

  function automatic logic [W-1:0] mk(input logic [2:0] dest, input logic [2:0] src,
                                      input logic [2:0] opq, input logic [31:0] pay);
    return {dest, src, opq, pay};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int idx, input logic [W-1:0] act, input string name);
    if (sb[idx].size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected message %h with nothing expected", name, act);
    end else begin
      check(name, 64'(act), 64'(sb[idx].pop_front()));
    end
  endtask

  // Monitor: every handshake on an observed port must match the next expected message.
  always @(negedge clk) begin
    if (reset) begin
      if (net_in_val_d0 && net_in_rdy_d0) pop_cmp(0, net_in_msg_d0, "net_in_d0");
      if (net_in_val_d1 && net_in_rdy_d1) pop_cmp(1, net_in_msg_d1, "net_in_d1");
      if (recv_val_d0 && recv_rdy_d0)     pop_cmp(2, recv_msg_d0, "recv_d0");
      if (recv_val_d1 && recv_rdy_d1)     pop_cmp(3, recv_msg_d1, "recv_d1");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] c_a  = {3'd1, 3'd2, 3'd0, 32'h0000_00aa};
  localparam logic [W-1:0] c_b  = {3'd6, 3'd2, 3'd7, 32'h0000_00bb};
  localparam logic [W-1:0] c_r1 = {3'd2, 3'd7, 3'd1, 32'h1234_5678};
  localparam logic [W-1:0] c_m1 = {3'd2, 3'd0, 3'd1, 32'h0000_0011};
  localparam logic [W-1:0] c_m2 = {3'd2, 3'd1, 3'd2, 32'h0000_0022};
  localparam logic [W-1:0] c_mr = {3'd5, 3'd1, 3'd3, 32'hcafe_f00d};

  initial begin
    reset = 1'b0; domain = 1'b0;
    send_val_d0 = 0; send_dest_d0 = 0; send_opaque_d0 = 0; send_payload_d0 = 0;
    send_val_d1 = 0; send_dest_d1 = 0; send_opaque_d1 = 0; send_payload_d1 = 0;
    net_in_rdy_d0 = 1; net_in_rdy_d1 = 1; recv_rdy_d0 = 1; recv_rdy_d1 = 1;
    net_out_val = 0; net_out_msg = '0;
    #3;
    check("rst_send_rdy_d0", 64'(send_rdy_d0), 64'd0);
    check("rst_net_out_rdy", 64'(net_out_rdy), 64'd0);
    check("rst_misroute_d0", 64'(misroute_d0), 64'd0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("idle_send_rdy_d1", 64'(send_rdy_d1), 64'd1);
    tick();

    // Injection on d0
    send_val_d0 = 1; send_dest_d0 = 3'd3; send_opaque_d0 = 3'd5; send_payload_d0 = 32'hdeadbeef;
    sb[0].push_back(mk(3'd3, 3'd2, 3'd5, 32'hdeadbeef));
    tick();
    send_val_d0 = 0;
    check("t1_net_in_val_d0", 64'(net_in_val_d0), 64'd1);
    check("t1_net_in_val_d1", 64'(net_in_val_d1), 64'd0);
    tick();

    // Backpressure on d1
    net_in_rdy_d1 = 0;
    send_val_d1 = 1; send_dest_d1 = 3'd1; send_opaque_d1 = 3'd0; send_payload_d1 = 32'haa;
    sb[1].push_back(c_a);
    sb[1].push_back(c_b);
    check("t2_rdy_empty", 64'(send_rdy_d1), 64'd1);
    tick();
    send_dest_d1 = 3'd6; send_opaque_d1 = 3'd7; send_payload_d1 = 32'hbb;
    check("t2_rdy_held", 64'(send_rdy_d1), 64'd0);
    check("t2_msg_a", 64'(net_in_msg_d1), 64'(c_a));
    tick();
    check("t2_msg_a_stable", 64'(net_in_msg_d1), 64'(c_a));
    net_in_rdy_d1 = 1;
    tick();
    send_val_d1 = 0;
    check("t2_b_val", 64'(net_in_val_d1), 64'd1);
    check("t2_b_msg", 64'(net_in_msg_d1), 64'(c_b));
    tick();
    check("t2_drained", 64'(net_in_val_d1), 64'd0);

    // Ejection into d1
    domain = 1; net_out_val = 1; net_out_msg = c_r1;
    sb[3].push_back(c_r1);
    check("t3_net_out_rdy", 64'(net_out_rdy), 64'd1);
    tick();
    net_out_val = 0;
    check("t3_recv_val_d1", 64'(recv_val_d1), 64'd1);
    check("t3_recv_val_d0", 64'(recv_val_d0), 64'd0);
    tick();

    // Fill d0 FIFO, check isolation of ready and no dequeue bypass
    recv_rdy_d0 = 0; domain = 0; net_out_val = 1; net_out_msg = c_m1;
    sb[2].push_back(c_m1);
    sb[2].push_back(c_m2);
    tick();
    net_out_msg = c_m2;
    tick();
    net_out_msg = c_mr;
    check("t4_full_rdy_d0", 64'(net_out_rdy), 64'd0);
    net_out_val = 0; domain = 1;
    #1;
    check("t4_rdy_d1", 64'(net_out_rdy), 64'd1);
    domain = 0; recv_rdy_d0 = 1;
    #1;
    check("t4_no_bypass", 64'(net_out_rdy), 64'd0);
    tick();
    check("t4_rdy_after_deq", 64'(net_out_rdy), 64'd1);
    tick();
    check("t4_empty", 64'(recv_val_d0), 64'd0);

    // Misroute on d0
    check("t5_flag_before", 64'(misroute_d0), 64'd0);
    net_out_val = 1; net_out_msg = c_mr;
    sb[2].push_back(c_mr);
    tick();
    net_out_val = 0;
    check("t5_flag_set", 64'(misroute_d0), 64'd1);
    check("t5_flag_d1", 64'(misroute_d1), 64'd0);
    tick();
    tick();
    check("t5_flag_sticky", 64'(misroute_d0), 64'd1);

    // Reset mid-traffic with everything occupied
    recv_rdy_d0 = 0; recv_rdy_d1 = 0; net_in_rdy_d0 = 0; net_in_rdy_d1 = 0;
    send_val_d0 = 1; send_val_d1 = 1;
    domain = 0; net_out_val = 1; net_out_msg = c_m1;
    tick();
    send_val_d0 = 0; send_val_d1 = 0; domain = 1; net_out_msg = c_m2;
    tick();
    net_out_val = 0;
    check("t6_pre_inj", 64'({net_in_val_d1, net_in_val_d0}), 64'd3);
    check("t6_pre_recv", 64'({recv_val_d1, recv_val_d0}), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_outs", 64'({recv_val_d1, recv_val_d0, net_in_val_d1, net_in_val_d0,
                              net_out_rdy, send_rdy_d1, send_rdy_d0}), 64'd0);
    check("t6_rst_flag", 64'(misroute_d0), 64'd0);
    net_in_rdy_d0 = 1; net_in_rdy_d1 = 1; recv_rdy_d0 = 1; recv_rdy_d1 = 1;
    tick();
    reset = 1'b1;
    #1;
    check("t6_post_recv", 64'({recv_val_d1, recv_val_d0}), 64'd0);
    check("t6_post_inj", 64'({net_in_val_d1, net_in_val_d0}), 64'd0);
    check("t6_post_rdy", 64'({net_out_rdy, send_rdy_d1, send_rdy_d0}), 64'd7);
    check("t6_post_flags", 64'({misroute_d1, misroute_d0}), 64'd0);
    tick(); tick();

    check("sb_drained", 64'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
